// File: rtl/sig_det_mc_pkg.sv
// Shared types for the multi-channel run-length detector.
// Counter/length fields are width-parameterised, so they live beside these structs in the lane.
package sig_det_pkg;
  localparam int MODE_PWM = 0;
  localparam int MODE_OWT = 1;

  typedef struct packed {
    logic last_data;
    logic have_last;
    logic long_flagged;
  } lane_flags_t;

  typedef struct packed {
    logic vld;
    logic data;
    logic err_short;
    logic err_long;
  } lane_evt_t;
endpackage

// File: rtl/sig_det_mc_if.sv
// Sample/threshold inputs and symbol/error outputs of sig_det_mc.
interface sig_det_mc_if #(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 10
);
  logic [CH_NUM-1:0]       i_vld;
  logic [CH_NUM-1:0]       i_data;
  logic [CH_NUM-1:0]       i_clr;
  logic [CNT_W-1:0]        i_dn_th;
  logic [CNT_W-1:0]        i_up_th;
  logic [CH_NUM-1:0]       o_vld;
  logic [CH_NUM-1:0]       o_data;
  logic [CH_NUM*CNT_W-1:0] o_len;
  logic [CH_NUM-1:0]       o_err_short;
  logic [CH_NUM-1:0]       o_err_long;
  logic                    o_cfg_err;

  modport slave (
    input  i_vld, i_data, i_clr, i_dn_th, i_up_th,
    output o_vld, o_data, o_len, o_err_short, o_err_long, o_cfg_err
  );
  modport master (
    output i_vld, i_data, i_clr, i_dn_th, i_up_th,
    input  o_vld, o_data, o_len, o_err_short, o_err_long, o_cfg_err
  );
endinterface

// File: rtl/sig_det_mc_ch.sv
// One detector lane: run-length tracking plus PWM window / OWT fixed-length symbol decisions.
module sig_det_ch
  import sig_det_pkg::*;
#(
  parameter int CNT_W = 10,
  parameter int MODE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sup,
  input  logic             vld,
  input  logic             data,
  input  logic             clr,
  input  logic [CNT_W-1:0] dn_th,
  input  logic [CNT_W-1:0] up_th,
  output lane_evt_t        evt,
  output logic [CNT_W-1:0] len
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  lane_flags_t      fl;
  logic [CNT_W:0]   inc;
  logic [CNT_W-1:0] cnt_sat;

  assign inc     = {1'b0, cnt} + (CNT_W+1)'(1);
  assign cnt_sat = (cnt == CNT_MAX) ? CNT_MAX : inc[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      fl  <= '0;
      evt <= '0;
      len <= '0;
    end else begin
      evt <= '0;
      len <= '0;
      if (clr && !vld) begin
        cnt <= '0;
        fl  <= '0;
      end else if (vld) begin
        if (!fl.have_last || clr) begin
          cnt             <= CNT_ONE;
          fl.last_data    <= data;
          fl.have_last    <= 1'b1;
          fl.long_flagged <= 1'b0;
        end else if (data == fl.last_data) begin
          if (MODE == MODE_OWT) begin
            if (inc == {1'b0, dn_th}) begin
              cnt <= '0;
              if (!sup) begin
                evt.vld  <= 1'b1;
                evt.data <= fl.last_data;
                len      <= dn_th;
              end
            end else begin
              cnt <= cnt_sat;
            end
          end else begin
            cnt <= cnt_sat;
            // cnt >= up_th (not ==) so a saturated or threshold-lowered run still flags once
            if (!fl.long_flagged && cnt >= up_th) begin
              fl.long_flagged <= 1'b1;
              if (!sup) begin
                evt.err_long <= 1'b1;
                len          <= cnt_sat;
              end
            end
          end
        end else begin
          cnt             <= CNT_ONE;
          fl.last_data    <= data;
          fl.long_flagged <= 1'b0;
          if (MODE == MODE_PWM && !fl.long_flagged && !sup) begin
            if (cnt >= dn_th && cnt <= up_th) begin
              evt.vld  <= 1'b1;
              evt.data <= fl.last_data;
              len      <= cnt;
            end else if (cnt < dn_th) begin
              evt.err_short <= 1'b1;
              len           <= cnt;
            end
          end
        end
      end
    end
  end
endmodule

// File: rtl/sig_det_mc.sv
// Multi-channel run-length detector top: lane array, config guard and output packing.
module sig_det_mc
  import sig_det_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 10,
  parameter int MODE   = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  sig_det_mc_if.slave  bus
);
  logic                              cfg_err;
  lane_evt_t                         evt [CH_NUM];
  logic [CH_NUM-1:0][CNT_W-1:0]      len;

  // Combinational guard gates pulses for the sample being accepted now
  assign cfg_err = (bus.i_dn_th == '0) ||
                   (MODE == MODE_PWM && bus.i_dn_th > bus.i_up_th);

  always_ff @(posedge i_clk) begin
    if (i_rst) bus.o_cfg_err <= 1'b0;
    else       bus.o_cfg_err <= cfg_err;
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    sig_det_ch #(.CNT_W(CNT_W), .MODE(MODE)) u_ch (
      .clk  (i_clk),
      .rst  (i_rst),
      .sup  (cfg_err),
      .vld  (bus.i_vld[c]),
      .data (bus.i_data[c]),
      .clr  (bus.i_clr[c]),
      .dn_th(bus.i_dn_th),
      .up_th(bus.i_up_th),
      .evt  (evt[c]),
      .len  (len[c])
    );
  end

  always_comb begin
    bus.o_vld       = '0;
    bus.o_data      = '0;
    bus.o_err_short = '0;
    bus.o_err_long  = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      bus.o_vld[c]       = evt[c].vld;
      bus.o_data[c]      = evt[c].data;
      bus.o_err_short[c] = evt[c].err_short;
      bus.o_err_long[c]  = evt[c].err_long;
    end
  end

  assign bus.o_len = len;
endmodule

// File: tb/tb_sig_det_mc.sv
// Directed bench for sig_det_mc: PWM (CNT_W=4), OWT (CNT_W=4) and saturating PWM (CNT_W=3) instances.
module tb_sig_det_mc;
  localparam int RST_DN_TH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sig_det_mc_if #(.CH_NUM(2), .CNT_W(4)) pb ();
  sig_det_mc_if #(.CH_NUM(2), .CNT_W(4)) ob ();
  sig_det_mc_if #(.CH_NUM(2), .CNT_W(3)) sb ();

  sig_det_mc #(.CH_NUM(2), .CNT_W(4), .MODE(0)) dut_pwm (.i_clk(clk), .i_rst(rst), .bus(pb));
  sig_det_mc #(.CH_NUM(2), .CNT_W(4), .MODE(1)) dut_owt (.i_clk(clk), .i_rst(rst), .bus(ob));
  sig_det_mc #(.CH_NUM(2), .CNT_W(3), .MODE(0)) dut_sat (.i_clk(clk), .i_rst(rst), .bus(sb));

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic p_smp(input logic [1:0] v, input logic [1:0] d, input logic [1:0] c);
    pb.i_vld = v; pb.i_data = d; pb.i_clr = c;
    tick();
    pb.i_vld = '0; pb.i_clr = '0;
  endtask

  task automatic o_smp(input logic [1:0] v, input logic [1:0] d);
    ob.i_vld = v; ob.i_data = d;
    tick();
    ob.i_vld = '0;
  endtask

  task automatic s_smp(input logic [1:0] v, input logic [1:0] d);
    sb.i_vld = v; sb.i_data = d;
    tick();
    sb.i_vld = '0;
  endtask

  initial begin
    int longs;
    pb.i_vld = '0; pb.i_data = '0; pb.i_clr = '0; pb.i_dn_th = 4'd3; pb.i_up_th = 4'd6;
    ob.i_vld = '0; ob.i_data = '0; ob.i_clr = '0; ob.i_dn_th = 4'd3; ob.i_up_th = 4'd15;
    sb.i_vld = '0; sb.i_data = '0; sb.i_clr = '0; sb.i_dn_th = 3'd1; sb.i_up_th = 3'd7;
    rst = 1'b1;
    tick(); tick();
    chk("rst_vld",  32'(pb.o_vld), 32'h0);
    chk("rst_len",  32'(pb.o_len), 32'h0);
    chk("rst_cfg",  32'(pb.o_cfg_err), 32'h0);
    rst = 1'b0;
    tick();
    chk("cfg_ok", 32'(pb.o_cfg_err), 32'h0);

    // PWM: 1,1,1,1,0 -> symbol 1 of length 4
    for (int i = 0; i < 4; i++) begin
      p_smp(2'b01, 2'b01, 2'b00);
      chk("pwm_run_quiet", 32'(pb.o_vld), 32'h0);
    end
    p_smp(2'b01, 2'b00, 2'b00);
    chk("pwm_sym_vld",  32'(pb.o_vld), 32'h1);
    chk("pwm_sym_data", 32'(pb.o_data), 32'h1);
    chk("pwm_sym_len",  32'(pb.o_len), 32'h04);
    chk("pwm_sym_nosh", 32'(pb.o_err_short), 32'h0);

    // 0,0,1 -> short error of length 2
    p_smp(2'b01, 2'b00, 2'b00);
    p_smp(2'b01, 2'b01, 2'b00);
    chk("short_err", 32'(pb.o_err_short), 32'h1);
    chk("short_len", 32'(pb.o_len), 32'h02);
    chk("short_vld", 32'(pb.o_vld), 32'h0);

    // ones 2..8: long error exactly on the 7th
    for (int i = 2; i <= 8; i++) begin
      p_smp(2'b01, 2'b01, 2'b00);
      chk("long_pulse", 32'(pb.o_err_long), (i == 7) ? 32'h1 : 32'h0);
      if (i == 7) chk("long_len", 32'(pb.o_len), 32'h07);
    end
    p_smp(2'b01, 2'b00, 2'b00);
    chk("long_end_vld", 32'(pb.o_vld), 32'h0);
    chk("long_end_err", 32'({pb.o_err_short, pb.o_err_long}), 32'h0);

    // lane1 builds cnt=5 while lane0 builds a 0-run of 6
    for (int i = 0; i < 5; i++) begin
      p_smp(2'b11, 2'b10, 2'b00);
      chk("dual_quiet", 32'({pb.o_vld, pb.o_err_short, pb.o_err_long}), 32'h0);
    end
    p_smp(2'b11, 2'b11, 2'b10);
    chk("clr_vld",  32'(pb.o_vld), 32'h1);
    chk("clr_data", 32'(pb.o_data), 32'h0);
    chk("clr_len",  32'(pb.o_len), 32'h06);
    chk("clr_err",  32'({pb.o_err_short, pb.o_err_long}), 32'h0);
    p_smp(2'b10, 2'b10, 2'b00);
    p_smp(2'b10, 2'b00, 2'b00);
    chk("restart_short", 32'(pb.o_err_short), 32'h2);
    chk("restart_len",   32'(pb.o_len), 32'h20);

    // clear without sample drops lane0 history
    p_smp(2'b00, 2'b00, 2'b01);
    chk("clr_only", 32'({pb.o_vld, pb.o_err_short}), 32'h0);
    p_smp(2'b01, 2'b00, 2'b00);
    chk("clr_fresh", 32'({pb.o_vld, pb.o_err_short}), 32'h0);

    // OWT: seven 1s, pulses after 3 and 6
    for (int i = 1; i <= 7; i++) begin
      o_smp(2'b01, 2'b01);
      chk("owt_vld", 32'(ob.o_vld), (i == 3 || i == 6) ? 32'h1 : 32'h0);
      if (i == 3 || i == 6) begin
        chk("owt_data", 32'(ob.o_data), 32'h1);
        chk("owt_len",  32'(ob.o_len), 32'h03);
      end
    end
    chk("owt_no_err", 32'({ob.o_err_short, ob.o_err_long}), 32'h0);

    // Saturation CNT_W=3, up=7: single long at sample 8, length 7
    longs = 0;
    for (int i = 1; i <= 20; i++) begin
      s_smp(2'b01, 2'b01);
      if (sb.o_err_long[0]) longs++;
      chk("sat_vld",  32'(sb.o_vld), 32'h0);
      chk("sat_long", 32'(sb.o_err_long), (i == 8) ? 32'h1 : 32'h0);
      if (i == 8) chk("sat_len", 32'(sb.o_len), 32'h07);
    end
    chk("sat_count", 32'(longs), 32'd1);
    s_smp(2'b01, 2'b00);
    chk("sat_end", 32'({sb.o_vld, sb.o_err_short, sb.o_err_long}), 32'h0);

    // Config error: dn=7 > up=4 suppresses pulses
    pb.i_dn_th = 4'd7; pb.i_up_th = 4'd4;
    tick();
    chk("cfg_err_hi", 32'(pb.o_cfg_err), 32'h1);
    for (int i = 0; i < 4; i++) begin
      p_smp(2'b01, 2'b00, 2'b00);
      chk("cfg_quiet", 32'({pb.o_vld, pb.o_err_short, pb.o_err_long}), 32'h0);
    end
    p_smp(2'b01, 2'b01, 2'b00);
    chk("cfg_change_quiet", 32'({pb.o_vld, pb.o_err_short, pb.o_err_long}), 32'h0);
    pb.i_dn_th = 4'd0; pb.i_up_th = 4'd6;
    tick();
    chk("cfg_dn0", 32'(pb.o_cfg_err), 32'h1);
    pb.i_dn_th = RST_DN_TH[3:0] - 4'd1;
    tick();
    chk("cfg_restore", 32'(pb.o_cfg_err), 32'h0);

    // Reset mid-run: lane0 1-run of 3, then 0 with reset asserted
    p_smp(2'b01, 2'b01, 2'b00);
    p_smp(2'b01, 2'b01, 2'b00);
    rst = 1'b1;
    p_smp(2'b01, 2'b00, 2'b00);
    chk("midrst_vld", 32'(pb.o_vld), 32'h0);
    chk("midrst_len", 32'(pb.o_len), 32'h0);
    chk("midrst_err", 32'({pb.o_err_short, pb.o_err_long}), 32'h0);
    rst = 1'b0;
    p_smp(2'b01, 2'b00, 2'b00);
    chk("postrst_quiet", 32'({pb.o_vld, pb.o_err_short, pb.o_err_long}), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
